// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
//
// Purpose:
//   Groups the instruction-fetch stage's two bus-like connections:
//     - the instruction-memory request/response pair (imem_addr / imem_inst)
//     - the IF/ID pipeline register contents handed to decode
//
// Signals:
//   imem_addr    32  byte address presented to instruction memory
//   imem_inst    32  instruction word returned combinationally for imem_addr
//   if_id_valid   1  IF/ID holds a real instruction
//   if_id_pc     32  PC of the instruction held in IF/ID
//   if_id_inst   32  instruction held in IF/ID (32'h0 when not valid)
//
// Modports:
//   master : the fetch stage (drives address and IF/ID, consumes imem_inst)
//   slave  : memory/decode side (drives imem_inst, consumes the rest)
// -----------------------------------------------------------------------------
interface fetch_stage_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_inst;

    modport master (
        output imem_addr,
        input  imem_inst,
        output if_id_valid,
        output if_id_pc,
        output if_id_inst
    );

    modport slave (
        input  imem_addr,
        output imem_inst,
        input  if_id_valid,
        input  if_id_pc,
        input  if_id_inst
    );
endinterface : fetch_stage_if

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Purpose:
//   Instruction-fetch stage. Owns the program counter, presents it as the byte
//   address to a combinational instruction memory and captures the returned
//   word into the IF/ID pipeline register. Supports hazard stalls, taken
//   branch/jump redirects (which flush IF/ID with one bubble) and detection of
//   the PC running past the end of instruction memory.
//
// Parameters:
//   IMEM_BYTES  size of instruction memory in bytes; a fetch at pc is legal
//               only when pc + 4 <= IMEM_BYTES
//   RESET_PC    word-aligned PC loaded on reset
//
// Ports:
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   stall           in   hold PC and IF/ID this cycle
//   redirect_valid  in   branch/jump taken this cycle (beats stall)
//   redirect_pc     in   redirect target; low two bits are dropped
//   bus             if   master side: imem_addr/imem_inst, if_id_* outputs
//   done            out  PC has run past the end of instruction memory
//   fetch_count     out  instructions loaded into IF/ID since reset (wraps)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned IMEM_BYTES = 48,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    fetch_stage_if.master        bus,
    output logic                 done,
    output logic [31:0]          fetch_count
);

    // Memory size widened to 33 bits so the range test cannot overflow.
    localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BYTES);

    // What the stage does this cycle, in priority order redirect > stall >
    // fetch / end-of-memory.
    typedef enum logic [1:0] {
        ACT_FETCH    = 2'd0,
        ACT_END      = 2'd1,
        ACT_STALL    = 2'd2,
        ACT_REDIRECT = 2'd3
    } fetch_act_t;

    // ---------------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------------
    logic [31:0] pc_r;
    logic        if_id_valid_r;
    logic [31:0] if_id_pc_r;
    logic [31:0] if_id_inst_r;
    logic        done_r;
    logic [31:0] fetch_count_r;

    // ---------------------------------------------------------------------
    // Next-state signals
    // ---------------------------------------------------------------------
    fetch_act_t  act_s;
    logic [32:0] pc_plus4_wide_s;
    logic        in_range_s;
    logic [31:0] redirect_aligned_s;
    logic [31:0] pc_next_s;
    logic        if_id_valid_next_s;
    logic [31:0] if_id_pc_next_s;
    logic [31:0] if_id_inst_next_s;
    logic        done_next_s;
    logic [31:0] fetch_count_next_s;

    // pc + 4 is formed in 33 bits: a pc near 2^32 yields a carry into bit 32
    // and therefore compares above any 32-bit memory size instead of wrapping
    // to a small, in-range address.
    assign pc_plus4_wide_s    = {1'b0, pc_r} + 33'd4;
    assign in_range_s         = (pc_plus4_wide_s <= IMEM_LIMIT);

    // Misaligned targets are silently rounded down to a word boundary.
    assign redirect_aligned_s = redirect_pc & 32'hFFFF_FFFC;

    // Select this cycle's action from the control inputs and the range check.
    always_comb begin
        act_s = ACT_FETCH;
        if (redirect_valid) begin
            act_s = ACT_REDIRECT;
        end else if (stall) begin
            act_s = ACT_STALL;
        end else if (in_range_s) begin
            act_s = ACT_FETCH;
        end else begin
            act_s = ACT_END;
        end
    end

    // Compute next PC, IF/ID contents, done flag and fetch counter.
    always_comb begin
        pc_next_s          = pc_r;
        if_id_valid_next_s = if_id_valid_r;
        if_id_pc_next_s    = if_id_pc_r;
        if_id_inst_next_s  = if_id_inst_r;
        done_next_s        = done_r;
        fetch_count_next_s = fetch_count_r;

        case (act_s)
            ACT_REDIRECT: begin
                // Flush: the redirect cycle itself becomes the one bubble.
                pc_next_s          = redirect_aligned_s;
                if_id_valid_next_s = 1'b0;
                if_id_pc_next_s    = 32'h0000_0000;
                if_id_inst_next_s  = 32'h0000_0000;
                done_next_s        = 1'b0;
            end
            ACT_STALL: begin
                // Everything holds; defaults already cover this.
                pc_next_s = pc_r;
            end
            ACT_FETCH: begin
                pc_next_s          = pc_plus4_wide_s[31:0];
                if_id_valid_next_s = 1'b1;
                if_id_pc_next_s    = pc_r;
                if_id_inst_next_s  = bus.imem_inst;
                fetch_count_next_s = fetch_count_r + 32'd1;
            end
            ACT_END: begin
                // Past the end of memory: park the PC and keep issuing bubbles
                // until a redirect or reset moves it somewhere legal.
                pc_next_s          = pc_r;
                if_id_valid_next_s = 1'b0;
                if_id_pc_next_s    = 32'h0000_0000;
                if_id_inst_next_s  = 32'h0000_0000;
                done_next_s        = 1'b1;
            end
            default: begin
                // Unreachable encoding: fall back to a safe bubble with PC held.
                pc_next_s          = pc_r;
                if_id_valid_next_s = 1'b0;
                if_id_pc_next_s    = 32'h0000_0000;
                if_id_inst_next_s  = 32'h0000_0000;
            end
        endcase
    end

    // State register: async reset to the architectural reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r          <= RESET_PC;
            if_id_valid_r <= 1'b0;
            if_id_pc_r    <= 32'h0000_0000;
            if_id_inst_r  <= 32'h0000_0000;
            done_r        <= 1'b0;
            fetch_count_r <= 32'h0000_0000;
        end else begin
            pc_r          <= pc_next_s;
            if_id_valid_r <= if_id_valid_next_s;
            if_id_pc_r    <= if_id_pc_next_s;
            if_id_inst_r  <= if_id_inst_next_s;
            done_r        <= done_next_s;
            fetch_count_r <= fetch_count_next_s;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs: all straight from registers; imem_addr is the PC itself.
    // ---------------------------------------------------------------------
    assign bus.imem_addr   = pc_r;
    assign bus.if_id_valid = if_id_valid_r;
    assign bus.if_id_pc    = if_id_pc_r;
    assign bus.if_id_inst  = if_id_inst_r;
    assign done            = done_r;
    assign fetch_count     = fetch_count_r;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Self-checking bench for fetch_stage. Instruction memory model returns
// 32'hA000_0000 | addr. Each directed step drives the control inputs, pushes
// the expected post-edge state onto a scoreboard queue, advances one clock
// and pops/compares against the DUT. Extra literal checks pin the scenario
// values called out for each test.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic        valid;
        logic [31:0] ipc;
        logic [31:0] inst;
        logic        done;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        done;
    logic [31:0] fetch_count;

    fetch_stage_if bus ();

    // Combinational instruction memory model.
    assign bus.imem_inst = 32'hA000_0000 | bus.imem_addr;

    fetch_stage #(
        .IMEM_BYTES (48),
        .RESET_PC   (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bus            (bus.master),
        .done           (done),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    exp_t sb_q[$];

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_valid;
    logic [31:0] m_ipc;
    logic [31:0] m_inst;
    logic        m_done;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_pc    = 32'h0;
        m_valid = 1'b0;
        m_ipc   = 32'h0;
        m_inst  = 32'h0;
        m_done  = 1'b0;
        m_cnt   = 32'h0;
    endtask

    // One clock: drive inputs, push expected result, clock, pop and compare.
    task automatic step(input logic s, input logic r, input logic [31:0] rpc, input string tag);
        exp_t e;
        stall          = s;
        redirect_valid = r;
        redirect_pc    = rpc;
        if (r) begin
            m_pc    = {rpc[31:2], 2'b00};
            m_valid = 1'b0;
            m_ipc   = 32'h0;
            m_inst  = 32'h0;
            m_done  = 1'b0;
        end else if (s) begin
            m_pc = m_pc;
        end else if ((64'(m_pc) + 64'd4) <= 64'd48) begin
            m_valid = 1'b1;
            m_ipc   = m_pc;
            m_inst  = 32'hA000_0000 | m_pc;
            m_pc    = m_pc + 32'd4;
            m_cnt   = m_cnt + 32'd1;
        end else begin
            m_valid = 1'b0;
            m_ipc   = 32'h0;
            m_inst  = 32'h0;
            m_done  = 1'b1;
        end
        e = '{pc: m_pc, valid: m_valid, ipc: m_ipc, inst: m_inst, done: m_done, cnt: m_cnt};
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({tag, ".imem_addr"},   bus.imem_addr,           e.pc);
        chk({tag, ".if_id_valid"}, {31'd0, bus.if_id_valid}, {31'd0, e.valid});
        chk({tag, ".if_id_pc"},    bus.if_id_pc,            e.ipc);
        chk({tag, ".if_id_inst"},  bus.if_id_inst,          e.inst);
        chk({tag, ".done"},        {31'd0, done},           {31'd0, e.done});
        chk({tag, ".fetch_count"}, fetch_count,             e.cnt);
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".imem_addr"},   bus.imem_addr,            32'h0);
        chk({tag, ".if_id_valid"}, {31'd0, bus.if_id_valid}, 32'h0);
        chk({tag, ".if_id_pc"},    bus.if_id_pc,             32'h0);
        chk({tag, ".if_id_inst"},  bus.if_id_inst,           32'h0);
        chk({tag, ".done"},        {31'd0, done},            32'h0);
        chk({tag, ".fetch_count"}, fetch_count,              32'h0);
    endtask

    initial begin
        model_reset();

        // ---- Reset state ----
        #12;
        chk_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ---- Reset and stream ----
        step(1'b0, 1'b0, 32'h0, "stream1");
        chk("stream1.inst_lit", bus.if_id_inst, 32'hA000_0000);
        step(1'b0, 1'b0, 32'h0, "stream2");
        chk("stream2.pc_lit",   bus.if_id_pc, 32'h0000_0004);
        chk("stream2.addr_lit", bus.imem_addr, 32'h0000_0008);
        chk("stream2.cnt_lit",  fetch_count, 32'd2);

        // ---- Stall 3 cycles at pc=0x8 ----
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, "stall");
        end
        chk("stall.addr_lit", bus.imem_addr, 32'h0000_0008);
        chk("stall.inst_lit", bus.if_id_inst, 32'hA000_0004);
        step(1'b0, 1'b0, 32'h0, "stall_release");
        chk("stall_release.pc_lit", bus.if_id_pc, 32'h0000_0008);
        step(1'b0, 1'b0, 32'h0, "to_0x10");

        // ---- Redirect with stall asserted, misaligned target 0x1E ----
        step(1'b1, 1'b1, 32'h0000_001E, "redir_stall");
        chk("redir_stall.addr_lit", bus.imem_addr, 32'h0000_001C);
        step(1'b0, 1'b0, 32'h0, "redir_target");
        chk("redir_target.inst_lit", bus.if_id_inst, 32'hA000_001C);

        // ---- Asynchronous reset mid-run at pc=0x14 ----
        step(1'b0, 1'b1, 32'h0000_0014, "redir_0x14");
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // ---- End of memory from 0 ----
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 1'b0, 32'h0, "run_to_end");
        end
        chk("end.last_pc_lit", bus.if_id_pc, 32'h0000_002C);
        step(1'b0, 1'b0, 32'h0, "end_edge");
        chk("end.done_lit",  {31'd0, done}, 32'd1);
        chk("end.addr_lit",  bus.imem_addr, 32'h0000_0030);
        chk("end.cnt_lit",   fetch_count, 32'd12);
        step(1'b0, 1'b0, 32'h0, "end_hold");
        step(1'b1, 1'b0, 32'h0, "end_stall");

        // Redirect clears done and resumes fetching.
        step(1'b0, 1'b1, 32'h0, "end_redir");
        chk("end_redir.done_lit", {31'd0, done}, 32'd0);
        step(1'b0, 1'b0, 32'h0, "resume");
        chk("resume.cnt_lit", fetch_count, 32'd13);

        // ---- Out-of-range redirect near 2^32 ----
        step(1'b0, 1'b1, 32'hFFFF_FFFC, "oor_redir");
        step(1'b0, 1'b0, 32'h0, "oor_done");
        chk("oor.addr_lit", bus.imem_addr, 32'hFFFF_FFFC);
        chk("oor.done_lit", {31'd0, done}, 32'd1);
        step(1'b0, 1'b0, 32'h0, "oor_hold");

        if (sb_q.size() != 0) begin
            failures++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_stage
